// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions: register addresses, field positions,
// exception codes and the EPC capture helper.
package cp0_pkg;

    // Register select values seen on cp0_addr
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR fields
    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    // Cause fields
    localparam int BD_BIT = 31;
    localparam int IP_HI  = 15;
    localparam int IP_LO  = 10;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Restart address for a victim: a delay-slot victim restarts at its
    // branch, one word earlier (32-bit wrap-around is intended).
    function automatic logic [31:0] victimEpc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_int_gen.sv
// Interrupt pending register (Cause.IP) and the gated interrupt request.
module cp0_int_gen
    import cp0_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hwInt,
    input  logic [5:0] srIm,
    input  logic       srIe,
    input  logic       srExl,
    output logic [5:0] causeIp,
    output logic       intReq
);

    logic [5:0] ipReg;
    logic [5:0] pendingBits;

    // IP samples the external lines on every edge, regardless of any
    // exception entry or ERET happening in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ipReg <= '0;
        end else begin
            ipReg <= hwInt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_mask
            assign pendingBits[gi] = ipReg[gi] & srIm[gi];
        end
    endgenerate

    assign causeIp = ipReg;
    assign intReq  = (|pendingBits) & srIe & ~srExl;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 state block: SR, Cause, EPC, PRId, exception entry / ERET
// bookkeeping and the MFC0/MTC0 access port.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h4255_4141,
    parameter logic [31:0] SR_RESET = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_we,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        exl_set,
    input  logic        write_protect,
    input  logic        eret,
    output logic        int_req,
    output logic [31:0] epc,
    output logic        exl
);

    // Architectural state (implemented bits only)
    logic [5:0]  srImReg;
    logic        srExlReg;
    logic        srIeReg;
    logic        causeBdReg;
    logic [4:0]  causeExcReg;
    logic [29:0] epcHiReg;
    logic [5:0]  causeIp;

    logic [31:0] victimPc;
    logic        mtc0Ok;
    logic        unusedBits;

    assign victimPc   = victimEpc(pc, bd);
    assign mtc0Ok     = cp0_we & ~write_protect;
    assign unusedBits = ^victimPc[1:0];

    cp0_int_gen u_int_gen (
        .clk     (clk),
        .reset   (reset),
        .hwInt   (hw_int),
        .srIm    (srImReg),
        .srIe    (srIeReg),
        .srExl   (srExlReg),
        .causeIp (causeIp),
        .intReq  (int_req)
    );

    // State update with priority entry > ERET > MTC0; entry drops any MTC0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            srImReg     <= SR_RESET[IM_HI:IM_LO];
            srExlReg    <= SR_RESET[EXL_BIT];
            srIeReg     <= SR_RESET[IE_BIT];
            causeBdReg  <= 1'b0;
            causeExcReg <= '0;
            epcHiReg    <= '0;
        end else if (exl_set) begin
            causeExcReg <= exc_code;
            // A nested entry keeps the original restart point.
            if (!srExlReg) begin
                causeBdReg <= bd;
                epcHiReg   <= victimPc[31:2];
            end
            srExlReg <= 1'b1;
        end else begin
            if (mtc0Ok) begin
                case (cp0_addr)
                    CP0_SR: begin
                        srImReg  <= cp0_wdata[IM_HI:IM_LO];
                        srIeReg  <= cp0_wdata[IE_BIT];
                        srExlReg <= cp0_wdata[EXL_BIT];
                    end
                    CP0_EPC: epcHiReg <= cp0_wdata[31:2];
                    default: ;
                endcase
            end
            // ERET clears EXL even when a concurrent SR write tries to set it.
            if (eret) begin
                srExlReg <= 1'b0;
            end
        end
    end

    // MFC0 read mux; unimplemented bits and addresses read as zero.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR: begin
                cp0_rdata[IM_HI:IM_LO] = srImReg;
                cp0_rdata[EXL_BIT]     = srExlReg;
                cp0_rdata[IE_BIT]      = srIeReg;
            end
            CP0_CAUSE: begin
                cp0_rdata[BD_BIT]        = causeBdReg;
                cp0_rdata[IP_HI:IP_LO]   = causeIp;
                cp0_rdata[EXC_HI:EXC_LO] = causeExcReg;
            end
            CP0_EPC:  cp0_rdata = {epcHiReg, 2'b00};
            CP0_PRID: cp0_rdata = PRID;
            default:  cp0_rdata = '0;
        endcase
    end

    assign epc = {epcHiReg, 2'b00};
    assign exl = srExlReg;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed vector table, reset corner sequence and a
// randomized run against a word-level reference model.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        exl_set;
    logic        write_protect;
    logic        eret;
    logic        int_req;
    logic [31:0] epc;
    logic        exl;

    int checks   = 0;
    int failures = 0;

    cp0_unit dut (
        .clk           (clk),
        .reset         (reset),
        .cp0_addr      (cp0_addr),
        .cp0_we        (cp0_we),
        .cp0_wdata     (cp0_wdata),
        .cp0_rdata     (cp0_rdata),
        .pc            (pc),
        .bd            (bd),
        .exc_code      (exc_code),
        .hw_int        (hw_int),
        .exl_set       (exl_set),
        .write_protect (write_protect),
        .eret          (eret),
        .int_req       (int_req),
        .epc           (epc),
        .exl           (exl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        wp;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        exlSet;
        logic        eretIn;
        logic [4:0]  exc;
        logic        bdIn;
        logic [31:0] pcIn;
        logic [5:0]  hw;
        logic [4:0]  rdAddr;
        logic [31:0] expRd;
        logic        expInt;
        logic        expExl;
        logic [31:0] expEpc;
    } vec_t;

    vec_t vecs [16];

    // Reference model state: whole register words as software sees them
    logic [31:0] mSr;
    logic [31:0] mCause;
    logic [31:0] mEpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        cp0_we        = 1'b0;
        cp0_wdata     = '0;
        write_protect = 1'b0;
        exl_set       = 1'b0;
        eret          = 1'b0;
        exc_code      = '0;
        bd            = 1'b0;
        pc            = '0;
    endtask

    // Reference: next register values from the rules, applied at an edge
    task automatic modelEdge();
        logic [31:0] restart;
        mCause = (mCause & ~32'h0000_FC00) | (32'(hw_int) << 10);
        if (exl_set) begin
            mCause = (mCause & ~32'h0000_007C) | (32'(exc_code) << 2);
            if (mSr[1] == 1'b0) begin
                restart = bd ? pc - 32'd4 : pc;
                mEpc    = restart & 32'hFFFF_FFFC;
                mCause  = bd ? (mCause | 32'h8000_0000) : (mCause & 32'h7FFF_FFFF);
            end
            mSr = mSr | 32'h2;
        end else begin
            if (cp0_we && !write_protect) begin
                if (cp0_addr == 5'd12) mSr  = cp0_wdata & 32'h0000_FC03;
                if (cp0_addr == 5'd14) mEpc = cp0_wdata & 32'hFFFF_FFFC;
            end
            if (eret) mSr = mSr & ~32'h2;
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a)
            5'd12:   return mSr;
            5'd13:   return mCause;
            5'd14:   return mEpc;
            5'd15:   return 32'h4255_4141;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic modelInt();
        logic [5:0] ip, im;
        ip = mCause[15:10];
        im = mSr[15:10];
        return ((ip & im) != 6'd0) && mSr[0] && !mSr[1];
    endfunction

    initial begin
        // fields: we wp addr wdata exlSet eret exc bd pc hw rdAddr expRd expInt expExl expEpc
        vecs[0]  = '{1'b1, 1'b0, 5'd12, 32'h0000_0401, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      6'h00, 5'd12, 32'h0000_0401, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      6'h01, 5'd13, 32'h0000_0400, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd0,  1'b1, 32'h3010,   6'h01, 5'd13, 32'h8000_0400, 1'b0, 1'b1, 32'h300C};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd12, 1'b0, 32'h3100,   6'h01, 5'd13, 32'h8000_0430, 1'b0, 1'b1, 32'h300C};
        vecs[4]  = '{1'b1, 1'b0, 5'd12, 32'h0000_FC03, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0,      6'h01, 5'd12, 32'h0000_FC01, 1'b1, 1'b0, 32'h300C};
        vecs[5]  = '{1'b1, 1'b0, 5'd14, 32'h1234_5678, 1'b1, 1'b0, 5'd4,  1'b0, 32'h4006,   6'h01, 5'd14, 32'h0000_4004, 1'b0, 1'b1, 32'h4004};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd0,  1'b0, 32'h0,      6'h01, 5'd12, 32'h0000_FC01, 1'b1, 1'b0, 32'h4004};
        vecs[7]  = '{1'b1, 1'b1, 5'd14, 32'h1234_5678, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      6'h01, 5'd14, 32'h0000_4004, 1'b1, 1'b0, 32'h4004};
        vecs[8]  = '{1'b1, 1'b0, 5'd14, 32'h1234_5678, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      6'h01, 5'd14, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b1, 1'b0, 5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      6'h01, 5'd13, 32'h0000_0410, 1'b1, 1'b0, 32'h1234_5678};
        vecs[10] = '{1'b1, 1'b0, 5'd15, 32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      6'h01, 5'd15, 32'h4255_4141, 1'b1, 1'b0, 32'h1234_5678};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd10, 1'b1, 32'h0,      6'h01, 5'd14, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC};
        vecs[12] = '{1'b1, 1'b0, 5'd14, 32'h0000_0007, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0,      6'h01, 5'd14, 32'h0000_0004, 1'b1, 1'b0, 32'h4};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      6'h00, 5'd3,  32'h0,         1'b0, 1'b0, 32'h4};
        vecs[14] = '{1'b1, 1'b0, 5'd12, 32'h0000_0002, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      6'h3F, 5'd12, 32'h0000_0002, 1'b0, 1'b1, 32'h4};
        vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd0,  1'b0, 32'h0,      6'h3F, 5'd13, 32'h8000_FC28, 1'b0, 1'b0, 32'h4};

        idleInputs();
        hw_int   = '0;
        cp0_addr = 5'd12;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        // Reset state
        #1;
        cp0_addr = 5'd12; #1 chk("rst_sr", cp0_rdata, 32'h0);
        cp0_addr = 5'd13; #1 chk("rst_cause", cp0_rdata, 32'h0);
        cp0_addr = 5'd14; #1 chk("rst_epc", cp0_rdata, 32'h0);
        cp0_addr = 5'd15; #1 chk("rst_prid", cp0_rdata, 32'h4255_4141);
        chk("rst_int_req", 32'(int_req), 32'h0);
        chk("rst_exl", 32'(exl), 32'h0);

        // Directed vector table, one edge per vector
        for (int i = 0; i < 16; i++) begin
            cp0_we        = vecs[i].we;
            write_protect = vecs[i].wp;
            cp0_addr      = vecs[i].addr;
            cp0_wdata     = vecs[i].wdata;
            exl_set       = vecs[i].exlSet;
            eret          = vecs[i].eretIn;
            exc_code      = vecs[i].exc;
            bd            = vecs[i].bdIn;
            pc            = vecs[i].pcIn;
            hw_int        = vecs[i].hw;
            @(posedge clk);
            #1;
            idleInputs();
            cp0_addr = vecs[i].rdAddr;
            #1;
            chk($sformatf("vec%0d_rdata", i), cp0_rdata, vecs[i].expRd);
            chk($sformatf("vec%0d_int_req", i), 32'(int_req), 32'(vecs[i].expInt));
            chk($sformatf("vec%0d_exl", i), 32'(exl), 32'(vecs[i].expExl));
            chk($sformatf("vec%0d_epc", i), epc, vecs[i].expEpc);
            $display("vec %0d addr=%0d rdata=%h int_req=%0d exl=%0d epc=%h",
                     i, cp0_addr, cp0_rdata, int_req, exl, epc);
        end

        // Asynchronous reset in the middle of a cycle wipes state at once
        exl_set = 1'b1; bd = 1'b0; pc = 32'h0000_8000; exc_code = 5'd5;
        @(posedge clk);
        #3;
        chk("pre_rst_epc", epc, 32'h0000_8000);
        reset = 1'b0;
        #1;
        chk("async_rst_exl", 32'(exl), 32'h0);
        chk("async_rst_epc", epc, 32'h0);
        cp0_addr = 5'd13; #1 chk("async_rst_cause", cp0_rdata, 32'h0);
        // An edge while held in reset must not capture the pending entry
        @(posedge clk);
        #1 chk("held_rst_exl", 32'(exl), 32'h0);
        idleInputs();
        hw_int = 6'h01;
        #2 reset = 1'b1;
        #1 chk("release_no_update_cause", cp0_rdata, 32'h0);
        @(posedge clk);
        #1 chk("first_edge_ip", cp0_rdata, 32'h0000_0400);
        $display("reset sequence done");

        // Randomized run against the reference model
        mSr    = 32'h0;
        mCause = 32'h0000_0400;
        mEpc   = 32'h0;
        for (int n = 0; n < 600; n++) begin
            logic [2:0] sel;
            sel           = 3'($urandom_range(0, 5));
            cp0_addr      = (sel < 3'd4) ? 5'(5'd12 + 5'(sel)) : 5'($urandom);
            cp0_we        = ($urandom_range(0, 2) == 0);
            write_protect = ($urandom_range(0, 3) == 0);
            exl_set       = ($urandom_range(0, 7) == 0);
            eret          = ($urandom_range(0, 6) == 0);
            exc_code      = 5'($urandom);
            bd            = 1'($urandom);
            pc            = ($urandom_range(0, 15) == 0) ? 32'h0 : 32'($urandom);
            cp0_wdata     = 32'($urandom);
            if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
            @(posedge clk);
            modelEdge();
            #1;
            chk($sformatf("rnd%0d_rdata", n), cp0_rdata, modelRead(cp0_addr));
            chk($sformatf("rnd%0d_int_req", n), 32'(int_req), 32'(modelInt()));
            chk($sformatf("rnd%0d_exl", n), 32'(exl), 32'(mSr[1]));
            chk($sformatf("rnd%0d_epc", n), epc, mEpc);
            $display("rnd %0d addr=%0d we=%0d wp=%0d exl_set=%0d eret=%0d rdata=%h epc=%h",
                     n, cp0_addr, cp0_we, write_protect, exl_set, eret, cp0_rdata, epc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 state block. It is the responder to the exception controller: it takes the entry request, captures EPC, Cause and BD, sets and clears SR.EXL, handles ERET, and produces the gated interrupt request `int_req` that the controller consumes.
- Sits beside the M stage. MFC0 and MTC0 access it through the addr/wdata/rdata ports.

Parameters:
- PRID, 32'h4255_4141, constant value returned for register 15.
- SR_RESET, 32'h0000_0000, SR value loaded at reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- cp0_addr  in  5  register select for read and write (12 SR, 13 Cause, 14 EPC, 15 PRId)
- cp0_we  in  1  MTC0 write enable
- cp0_wdata  in  32  MTC0 write data
- cp0_rdata  out  32  MFC0 read data, combinational from cp0_addr
- pc  in  32  PC of the M-stage victim instruction
- bd  in  1  victim sits in a branch delay slot
- exc_code  in  5  exception code [6:2]; 0 means interrupt
- hw_int  in  6  external interrupt lines [7:2]
- exl_set  in  1  exception/interrupt entry accepted this cycle
- write_protect  in  1  suppress MTC0 this cycle
- eret  in  1  ERET retiring this cycle
- int_req  out  1  gated interrupt request
- epc  out  32  current EPC, for ERET redirect
- exl  out  1  SR.EXL

Behaviour:
- Reset (asynchronous, active-low):
  - SR = SR_RESET.
  - Cause = 0 and EPC = 0.
  - Outputs: int_req = 0, epc = 0, exl = SR_RESET[1], cp0_rdata follows cp0_addr.
  - Reset asserted mid-update overrides everything; the first update comes on the first rising edge after release.
- Implemented bits: all others read 0 and ignore writes.
  - SR: IM[15:10], EXL[1], IE[0].
  - Cause: BD[31], IP[15:10], ExcCode[6:2].
  - EPC: [31:2]; bits [1:0] always 0.
  - PRId: the PRID constant.
- Read port: cp0_rdata = selected register, combinational, 1 cycle zero latency. Unimplemented addresses return 0. There is no write-to-read bypass.
- Cause.IP is loaded from hw_int on every edge, unconditionally, including during entry and ERET.
- int_req = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL, combinational from registered state.
  - Latency: hw_int asserted before edge k gives int_req high after edge k.
- Per-edge priority: exl_set > eret > cp0_we.
- When exl_set = 1:
  - Cause.ExcCode <= exc_code.
  - If SR.EXL was 0: Cause.BD <= bd; EPC <= bd ? pc - 4 : pc, with [1:0] forced to 0.
  - If SR.EXL was already 1 (nested): EPC and BD are unchanged; only ExcCode updates.
  - SR.EXL <= 1.
  - Any MTC0 in the same cycle is dropped, whether or not write_protect is asserted.
- When eret = 1 and exl_set = 0:
  - SR.EXL <= 0.
  - A simultaneous MTC0 to SR updates IM and IE; EXL still clears.
  - A simultaneous MTC0 to EPC is applied.
- When cp0_we = 1, write_protect = 0 and no entry:
  - Address 12: writes IM, EXL, IE.
  - Address 14: writes EPC[31:2].
  - Addresses 13, 15 and others: no effect (Cause and PRId are not writable).
- epc output = registered EPC.
- pc - 4 arithmetic is 32-bit modulo; pc = 0 with bd = 1 wraps to 32'hFFFF_FFFC.

Decomposition:
- Shared package cp0_pkg holds:
  - register addresses: CP0_SR = 12, CP0_CAUSE = 13, CP0_EPC = 14, CP0_PRID = 15;
  - bit-field positions: IM_HI/LO, EXL_BIT, IE_BIT, BD_BIT, IP_HI/LO, EXC_HI/LO;
  - ExcCode constants: EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12.
- One natural sub-module, cp0_int_gen: the IP register plus the int_req gating. Everything else stays inline.

Test Plan:
1. Reset low, then release → reading 12/13/14/15 gives 0, 0, 0, 32'h4255_4141; int_req = 0.
2. MTC0 SR = 32'h0000_0401, then hw_int = 6'b000001 → Cause reads 32'h0000_0400 after the next edge; int_req goes 1 one edge after hw_int.
3. exl_set = 1, exc_code = 0, bd = 1, pc = 32'h0000_3010 → EPC = 32'h0000_300C, Cause = 32'h8000_0400, exl = 1, int_req = 0.
4. With EXL = 1, exl_set = 1, exc_code = 12, pc = 32'h0000_3100, bd = 0 → EPC unchanged at 32'h0000_300C, ExcCode = 12, BD still 1.
5. Same cycle: eret = 1 and MTC0 SR = 32'h0000_FC03 → SR reads 32'h0000_FC01 (EXL cleared, IM/IE written); int_req = 1 if IP is nonzero.
6. Same cycle: exl_set = 1 and MTC0 EPC = 32'h1234_5678 → EPC takes the exception value, not the write; MTC0 with write_protect = 1 alone → no change.
